// File: rtl/test_pattern_seq_pkg.sv
// ---------------------------------------------------------------------------
// test_pattern_seq_pkg -- shared enums and constants for test_pattern_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package test_pattern_seq_pkg;

  typedef enum logic [1:0] {
    MODE_COUNTER = 2'd0,
    MODE_WALK1   = 2'd1,
    MODE_FIXED   = 2'd2,
    MODE_LFSR    = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // x^32 + x^22 + x^2 + x + 1, Fibonacci form
  localparam logic [31:0] LFSR_TAPS_DEFAULT = 32'h80200003;

endpackage

`default_nettype wire

// File: rtl/test_pattern_sequencer_if.sv
// ---------------------------------------------------------------------------
// test_pattern_sequencer_if -- valid/ready pattern stream with last marker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface test_pattern_sequencer_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);

endinterface

`default_nettype wire

// File: rtl/tps_pattern_gen.sv
// ---------------------------------------------------------------------------
// tps_pattern_gen -- pattern register with seed load and per-mode advance;
// LFSR mode only with TEST_PATTERN_SEQ_LFSR_EN, otherwise mode 3 counts. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tps_pattern_gen
  import test_pattern_seq_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] LFSR_TAPS  = LFSR_TAPS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  mode_t                 mode,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [DATA_WIDTH-1:0] pattern
);

`ifdef TEST_PATTERN_SEQ_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(LFSR_TAPS);

  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] next_val;
  logic [DATA_WIDTH-1:0] count_next;
  logic [DATA_WIDTH-1:0] lfsr_next;

  always_comb begin
    count_next = pattern + DATA_WIDTH'(1);
    lfsr_next  = {pattern[DATA_WIDTH-2:0], ^(pattern & TAPS)};
    load_val   = seed;
    next_val   = count_next;
    case (mode)
      MODE_WALK1: begin
        // an all-zero seed would never show a walking bit
        load_val = (seed == '0) ? DATA_WIDTH'(1) : seed;
        next_val = {pattern[DATA_WIDTH-2:0], pattern[DATA_WIDTH-1]};
      end
      MODE_FIXED: next_val = pattern;
      MODE_LFSR: begin
        load_val = (LFSR_ON && seed == '0) ? '1 : seed;
        next_val = LFSR_ON ? lfsr_next : count_next;
      end
      default: next_val = count_next;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= '0;
    end else if (load) begin
      pattern <= load_val;
    end else if (advance) begin
      pattern <= next_val;
    end
  end

endmodule

`default_nettype wire

// File: rtl/test_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// test_pattern_sequencer -- start-triggered burst generator on a valid/ready
// stream; macro TEST_PATTERN_SEQ_LFSR_EN enables LFSR mode. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module test_pattern_sequencer
  import test_pattern_seq_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          LEN_WIDTH  = 16,
  parameter int          GAP_WIDTH  = 8,
  parameter logic [31:0] LFSR_TAPS  = LFSR_TAPS_DEFAULT
) (
  input  logic                  axi_clk,
  input  logic                  axi_resetn,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [1:0]            cfg_mode,
  input  logic [LEN_WIDTH-1:0]  cfg_burst_len,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  test_pattern_sequencer_if.master m,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  word_count
);

  state_t                state;
  state_t                next_state;
  mode_t                 mode_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  count_r;
  logic [GAP_WIDTH-1:0]  gap_r;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic [DATA_WIDTH-1:0] seed_r;
  logic [DATA_WIDTH-1:0] pattern;
  logic                  abort_pend;
  logic                  idle;
  logic                  start_ok;
  logic                  accept;
  logic                  last_word;
  logic                  load_pat;

  always_comb begin
    idle       = (state == S_IDLE) || (state == S_DONE);
    start_ok   = idle && cfg_start && !cfg_abort;
    accept     = (state == S_SEND) && m.ready;
    last_word  = (state == S_SEND) && (len_r != '0) && (count_r == len_r - LEN_WIDTH'(1));
    load_pat   = (state == S_LOAD);
    next_state = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) next_state = S_LOAD;
      S_LOAD:         next_state = cfg_abort ? S_DONE : S_SEND;
      S_SEND: begin
        // a stalled word is never withdrawn; abort takes effect on its acceptance
        if (accept) begin
          if (last_word || abort_pend || cfg_abort) next_state = S_DONE;
          else if (gap_r != '0)                    next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (cfg_abort)                                  next_state = S_DONE;
        else if (gap_cnt == gap_r - GAP_WIDTH'(1))      next_state = S_SEND;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state      <= S_IDLE;
      mode_r     <= MODE_COUNTER;
      len_r      <= '0;
      gap_r      <= '0;
      seed_r     <= '0;
      count_r    <= '0;
      gap_cnt    <= '0;
      abort_pend <= 1'b0;
    end else begin
      state <= next_state;
      if (start_ok) begin
        mode_r     <= mode_t'(cfg_mode);
        len_r      <= cfg_burst_len;
        gap_r      <= cfg_gap;
        seed_r     <= cfg_seed;
        count_r    <= '0;
        abort_pend <= 1'b0;
      end
      if (accept) begin
        count_r <= count_r + LEN_WIDTH'(1);
        gap_cnt <= '0;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + GAP_WIDTH'(1);
      end
      if ((state == S_SEND) && cfg_abort && !m.ready) abort_pend <= 1'b1;
    end
  end

  tps_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .LFSR_TAPS  (LFSR_TAPS)
  ) u_gen (
    .clk     (axi_clk),
    .rst_n   (axi_resetn),
    .load    (load_pat),
    .advance (accept),
    .mode    (mode_r),
    .seed    (seed_r),
    .pattern (pattern)
  );

  assign m.valid    = (state == S_SEND);
  assign m.data     = pattern;
  assign m.last     = last_word;
  assign busy       = (state == S_LOAD) || (state == S_SEND) || (state == S_GAP);
  assign done       = (state == S_DONE);
  assign word_count = count_r;

endmodule

`default_nettype wire
